// File: rtl/modpoly_pkg.sv
// Shared constants and types for the polynomial coefficient RAM sequencer.
package modpoly_pkg;

    localparam int unsigned N             = 757;
    localparam int unsigned Q             = 5167;
    localparam int unsigned RAM_WIDTH     = 13;
    localparam int unsigned RAM_ADDR_BITS = 11;
    localparam int unsigned CNT_BITS      = 10;

    typedef logic [RAM_WIDTH-1:0]     coef_t;
    typedef logic [RAM_ADDR_BITS-1:0] addr_t;
    typedef logic [CNT_BITS-1:0]      cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StLoad,
        StRead
    } state_t;

    localparam cnt_t  LAST_IDX = cnt_t'(N - 1);
    localparam cnt_t  N_CNT    = cnt_t'(N);
    localparam coef_t Q_COEF   = coef_t'(Q);

endpackage

// File: rtl/modpoly_rd_stage.sv
// Output register stage for the read-out stream: issues one RAM read per free slot
// and holds data/valid/last stable under backpressure.
module modpoly_rd_stage
    import modpoly_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 active,
    input  logic [CNT_BITS-1:0]  issued,
    input  logic [RAM_WIDTH-1:0] ram_rdata,
    input  logic                 out_ready,
    output logic                 issue,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last
);

    coef_t data_q;
    logic  valid_q;
    logic  last_q;

    // Issue whenever the output slot is empty or being drained and beats remain.
    always_comb begin
        issue = active && (!valid_q || out_ready) && (issued < N_CNT);
    end

    // Output register: load on issue, clear valid on acceptance without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (issue) begin
            data_q  <= ram_rdata;
            valid_q <= 1'b1;
            last_q  <= (issued == LAST_IDX);
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: rtl/modpoly_mem_ctrl.sv
// Sequencer for one 2048x13 coefficient RAM: zero-fill, streaming load and
// streaming read-out of an N-coefficient polynomial starting at a base address.
// Optional load range check enabled by defining MODPOLY_RANGE_CHK_EN.
module modpoly_mem_ctrl
    import modpoly_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_clear,
    input  logic                     cmd_load,
    input  logic                     cmd_read,
    input  logic [RAM_ADDR_BITS-1:0] cmd_base,
    output logic                     busy,
    output logic                     done,
    input  logic [RAM_WIDTH-1:0]     in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     range_err,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_waddr,
    output logic [RAM_WIDTH-1:0]     ram_wdata,
    output logic [RAM_ADDR_BITS-1:0] ram_raddr,
    input  logic [RAM_WIDTH-1:0]     ram_rdata
);

    state_t state_q, state_d;
    addr_t  ptr_q, ptr_d;
    cnt_t   cnt_q, cnt_d;
    logic   done_q, done_d;
    logic   rd_issue;

    // State, pointer, counter and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and RAM write port control.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        in_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_clear || cmd_load || cmd_read) begin
                    ptr_d = cmd_base;
                    cnt_d = '0;
                    if (cmd_clear) begin
                        state_d = StClear;
                    end else if (cmd_load) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StClear: begin
                ram_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ram_we    = 1'b1;
                    ram_wdata = in_data;
                    ptr_d     = ptr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StRead: begin
                if (rd_issue) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
                // The last beat is issued before it can be accepted, so no issue overlaps this.
                if (out_valid && out_ready && out_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign ram_waddr = ptr_q;
    assign ram_raddr = ptr_q;

    modpoly_rd_stage u_rd_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (state_q == StRead),
        .issued    (cnt_q),
        .ram_rdata (ram_rdata),
        .out_ready (out_ready),
        .issue     (rd_issue),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

`ifdef MODPOLY_RANGE_CHK_EN
    logic cmd_accept;
    logic range_err_q;

    assign cmd_accept = (state_q == StIdle) && (cmd_clear || cmd_load || cmd_read);

    // Sticky out-of-range flag for load beats; the beat itself is still written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else if (cmd_accept) begin
            range_err_q <= 1'b0;
        end else if ((state_q == StLoad) && in_valid && (in_data >= Q_COEF)) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_modpoly_mem_ctrl.sv
// Self-checking bench for modpoly_mem_ctrl with a behavioural 2048x13 RAM model.
module tb_modpoly_mem_ctrl;
    import modpoly_pkg::*;

`ifdef MODPOLY_RANGE_CHK_EN
    localparam bit RangeOn = 1'b1;
`else
    localparam bit RangeOn = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] addr;
        logic [12:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_clear = 1'b0, cmd_load = 1'b0, cmd_read = 1'b0;
    logic [10:0] cmd_base = '0;
    logic        busy, done;
    logic [12:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] out_data;
    logic        out_valid, out_last;
    logic        out_ready = 1'b0;
    logic        range_err;
    logic        ram_we;
    logic [10:0] ram_waddr, ram_raddr;
    logic [12:0] ram_wdata, ram_rdata;

    logic [12:0] mem [0:2047];
    logic        bk_we = 1'b0;
    logic [10:0] bk_addr = '0;
    logic [12:0] bk_data = '0;

    int checks = 0;
    int failures = 0;

    wr_t         exp_q[$];
    logic [12:0] rd_q[$];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        else if (bk_we) mem[bk_addr] <= bk_data;
    end
    assign ram_rdata = mem[ram_raddr];

    modpoly_mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_clear (cmd_clear),
        .cmd_load  (cmd_load),
        .cmd_read  (cmd_read),
        .cmd_base  (cmd_base),
        .busy      (busy),
        .done      (done),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .range_err (range_err),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [12:0] pattern(int a);
        return 13'((a * 37 + 11) % 8191);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, in_ready, out_valid, out_last, ram_we, range_err} !== 7'b0)
            begin failures++; $display("FAIL reset_flags got=%b want=0",
                {busy, done, in_ready, out_valid, out_last, ram_we, range_err}); end
        checks++;
        if ({out_data, ram_waddr, ram_wdata, ram_raddr} !== 48'b0)
            begin failures++; $display("FAIL reset_buses got=%h want=0",
                {out_data, ram_waddr, ram_wdata, ram_raddr}); end
        rst_n = 1'b1;
    endtask

    task automatic prefill();
        for (int a = 0; a < 757; a++) begin
            @(negedge clk);
            bk_we = 1'b1; bk_addr = 11'(a); bk_data = pattern(a);
        end
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    task automatic test_reset_midop();
        int bad_keep;
        int bad_zero;
        prefill();
        @(negedge clk);
        cmd_clear = 1'b1; cmd_base = 11'h000;
        @(posedge clk); #1;
        cmd_clear = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, in_ready, out_valid, out_last, ram_we, range_err} !== 7'b0)
            begin failures++; $display("FAIL midop_reset_flags got=%b want=0",
                {busy, done, in_ready, out_valid, out_last, ram_we, range_err}); end
        checks++;
        if ({out_data, ram_waddr, ram_wdata, ram_raddr} !== 48'b0)
            begin failures++; $display("FAIL midop_reset_buses got=%h want=0",
                {out_data, ram_waddr, ram_wdata, ram_raddr}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                begin failures++; $display("FAIL midop_no_done done=%b busy=%b want 0 0",
                    done, busy); end
        end
        bad_keep = 0;
        bad_zero = 0;
        for (int a = 100; a < 757; a++) if (mem[a] !== pattern(a)) bad_keep++;
        for (int a = 0; a < 100; a++) if (mem[a] !== 13'd0) bad_zero++;
        checks++;
        if (bad_keep != 0)
            begin failures++; $display("FAIL midop_keep bad_words=%0d want 0", bad_keep); end
        checks++;
        if (bad_zero != 0)
            begin failures++; $display("FAIL midop_zeroed bad_words=%0d want 0", bad_zero); end
    endtask

    task automatic test_clear();
        wr_t w;
        int  cyc;
        exp_q.delete();
        for (int i = 0; i < 757; i++) exp_q.push_back({11'(11'h100 + i), 13'd0});
        @(negedge clk);
        cmd_clear = 1'b1; cmd_base = 11'h100;
        @(posedge clk); #1;
        cmd_clear = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
            checks++;
            if (ram_we !== 1'b1 || done !== 1'b0 || busy !== 1'b1)
                begin failures++; $display("FAIL clear_cycle we=%b done=%b busy=%b want 1 0 1",
                    ram_we, done, busy); end
            if (ram_we === 1'b1) begin
                w = exp_q.pop_front();
                checks++;
                if ({ram_waddr, ram_wdata} !== {w.addr, w.data})
                    begin failures++; $display("FAIL clear_write addr=%h data=%h want %h %h",
                        ram_waddr, ram_wdata, w.addr, w.data); end
            end
        end
        checks++;
        if (exp_q.size() != 0)
            begin failures++; $display("FAIL clear_timeout left=%0d want 0", exp_q.size()); end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0)
            begin failures++; $display("FAIL clear_done done=%b busy=%b we=%b want 1 0 0",
                done, busy, ram_we); end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0)
            begin failures++; $display("FAIL clear_pulse done=%b want 0", done); end
    endtask

    task automatic test_load_wrap();
        wr_t w;
        int  cyc;
        int  idx;
        exp_q.delete();
        for (int i = 0; i < 757; i++) exp_q.push_back({11'(11'h7F0 + i), 13'(i)});
        @(negedge clk);
        cmd_load = 1'b1; cmd_base = 11'h7F0;
        @(posedge clk); #1;
        cmd_load = 1'b0;
        cyc = 0;
        idx = 0;
        while (exp_q.size() != 0 && cyc < 4000) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 13'(idx);
            #1;
            cyc++;
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
                begin failures++; $display("FAIL load_state ready=%b busy=%b done=%b want 1 1 0",
                    in_ready, busy, done); end
            if (in_valid) begin
                w = exp_q.pop_front();
                idx++;
                checks++;
                if ({ram_we, ram_waddr, ram_wdata} !== {1'b1, w.addr, w.data})
                    begin failures++; $display("FAIL load_write we=%b addr=%h data=%h want 1 %h %h",
                        ram_we, ram_waddr, ram_wdata, w.addr, w.data); end
            end else begin
                checks++;
                if (ram_we !== 1'b0)
                    begin failures++; $display("FAIL load_gap we=%b want 0", ram_we); end
            end
        end
        checks++;
        if (exp_q.size() != 0)
            begin failures++; $display("FAIL load_timeout left=%0d want 0", exp_q.size()); end
        @(negedge clk);
        in_valid = 1'b1; in_data = 13'h0AA;
        #1;
        checks++;
        if ({done, busy, in_ready, ram_we} !== 4'b1000)
            begin failures++; $display("FAIL load_done done/busy/ready/we=%b want 1000",
                {done, busy, in_ready, ram_we}); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_read();
        logic [12:0] w;
        int          cyc;
        logic        prev_valid, prev_ready, prev_last;
        logic [12:0] prev_data;
        rd_q.delete();
        for (int i = 0; i < 757; i++) rd_q.push_back(13'(i));
        @(negedge clk);
        cmd_read = 1'b1; cmd_base = 11'h7F0;
        @(posedge clk); #1;
        cmd_read = 1'b0;
        cyc = 0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;
        while (rd_q.size() != 0 && cyc < 4000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b1)
                    begin failures++; $display("FAIL read_first valid=%b busy=%b want 0 1",
                        out_valid, busy); end
            end else if (cyc == 2) begin
                checks++;
                if (out_valid !== 1'b1)
                    begin failures++; $display("FAIL read_latency valid=%b want 1", out_valid); end
            end
            if (prev_valid && !prev_ready) begin
                checks++;
                if ({out_valid, out_last, out_data} !== {1'b1, prev_last, prev_data})
                    begin failures++; $display("FAIL read_stall got=%b/%b/%h want 1/%b/%h",
                        out_valid, out_last, out_data, prev_last, prev_data); end
            end
            checks++;
            if (ram_we !== 1'b0 || done !== 1'b0)
                begin failures++; $display("FAIL read_idle_we we=%b done=%b want 0 0",
                    ram_we, done); end
            if (out_valid === 1'b1 && out_ready) begin
                w = rd_q.pop_front();
                checks++;
                if ({out_data, out_last} !== {w, rd_q.size() == 0})
                    begin failures++; $display("FAIL read_beat data=%h last=%b want %h %b",
                        out_data, out_last, w, rd_q.size() == 0); end
            end
            prev_valid = out_valid; prev_ready = out_ready;
            prev_last = out_last; prev_data = out_data;
        end
        checks++;
        if (rd_q.size() != 0)
            begin failures++; $display("FAIL read_timeout left=%0d want 0", rd_q.size()); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if ({done, busy, out_valid} !== 3'b100)
            begin failures++; $display("FAIL read_done done/busy/valid=%b want 100",
                {done, busy, out_valid}); end
    endtask

    task automatic test_simul();
        int   cyc;
        int   nwr;
        logic got_done;
        @(negedge clk);
        cmd_clear = 1'b1; cmd_load = 1'b1; cmd_read = 1'b1; cmd_base = 11'h000;
        @(posedge clk); #1;
        cmd_clear = 1'b0; cmd_load = 1'b0; cmd_read = 1'b0;
        cyc = 0; nwr = 0; got_done = 1'b0;
        while (!got_done && cyc < 2000) begin
            @(negedge clk);
            cmd_read = (cyc >= 10 && cyc < 20);
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            cyc++;
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                checks++;
                if ({ram_we, ram_wdata, in_ready, out_valid} !== {1'b1, 13'd0, 1'b0, 1'b0})
                    begin failures++; $display("FAIL simul_clear we=%b wdata=%h ready=%b valid=%b",
                        ram_we, ram_wdata, in_ready, out_valid); end
                if (ram_we === 1'b1) nwr++;
            end
        end
        cmd_read = 1'b0;
        checks++;
        if (!got_done || nwr != 757)
            begin failures++; $display("FAIL simul_count done=%b writes=%0d want 1 757",
                got_done, nwr); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0)
                begin failures++; $display("FAIL simul_no_read busy=%b valid=%b want 0 0",
                    busy, out_valid); end
        end
    endtask

    task automatic test_range();
        logic exp_err;
        int   cyc;
        @(negedge clk);
        cmd_load = 1'b1; cmd_base = 11'h000;
        @(posedge clk); #1;
        cmd_load = 1'b0;
        for (int i = 0; i < 757; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (i == 3) ? 13'd5167 : 13'(i);
            #1;
            exp_err = RangeOn && (i > 3);
            checks++;
            if (range_err !== exp_err)
                begin failures++; $display("FAIL range_flag beat=%0d got=%b want %b",
                    i, range_err, exp_err); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({done, range_err} !== {1'b1, RangeOn})
            begin failures++; $display("FAIL range_done done/err=%b want 1%b",
                {done, range_err}, RangeOn); end
        checks++;
        if (mem[3] !== 13'd5167)
            begin failures++; $display("FAIL range_word got=%0d want 5167", mem[3]); end
        @(negedge clk);
        cmd_read = 1'b1; cmd_base = 11'h000; out_ready = 1'b1;
        #1;
        checks++;
        if (range_err !== RangeOn)
            begin failures++; $display("FAIL range_hold got=%b want %b", range_err, RangeOn); end
        @(posedge clk); #1;
        cmd_read = 1'b0;
        checks++;
        if (range_err !== 1'b0)
            begin failures++; $display("FAIL range_clear got=%b want 0", range_err); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || range_err !== 1'b0)
            begin failures++; $display("FAIL range_drain done=%b err=%b want 1 0",
                done, range_err); end
    endtask

    initial begin
        test_reset();
        test_reset_midop();
        test_clear();
        test_load_wrap();
        test_read();
        test_simul();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
